inst_mem_loader: RTL

- Boot loader that fills the instruction memory from a byte stream (UART receiver or testbench) before the processor runs.
- Assembles incoming bytes into 32-bit big-endian words and drives the instruction memory write port at sequential addresses.
- Ends each load by checking a trailing XOR checksum byte.
- Sits between the serial front end and the instruction memory; busy holds the core in reset while a load is in progress.

---
 rtl/inst_mem_loader.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/inst_mem_loader.sv
// Boot loader: packs a big-endian byte stream into 32-bit words, writes them to
// sequential instruction-memory addresses, then verifies a trailing XOR checksum byte.
module inst_mem_loader #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_SIZE-1:0]  mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_CHECK
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   r_addr;
  logic [1:0]            r_byte_idx;
  logic [WORD_SIZE-1:0]  r_word;
  logic [7:0]            r_csum;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [WORD_SIZE-1:0]  r_mem_wdata;
  logic                  r_done;
  logic                  r_error;

  logic [ADDR_WIDTH:0]   w_count_sat;
  logic [ADDR_WIDTH:0]   w_addr_inc;
  logic [WORD_SIZE-1:0]  w_word_shift;
  logic                  w_take;

  assign w_count_sat  = (word_count > LP_DEPTH) ? LP_DEPTH : word_count;
  assign w_addr_inc   = r_addr + 1'b1;
  assign w_word_shift = {r_word[WORD_SIZE-9:0], byte_in};
  assign w_take       = byte_valid && byte_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // byte_ready and busy decode straight from the state; everything else is registered.
  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (start) w_next = (w_count_sat != '0) ? S_RECV : S_CHECK;
      end
      S_RECV: begin
        byte_ready = 1'b1;
        if (byte_valid && (r_byte_idx == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_next = (w_addr_inc == r_count) ? S_CHECK : S_RECV;
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_addr      <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
      r_csum      <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_count    <= w_count_sat;
            r_addr     <= '0;
            r_byte_idx <= '0;
            r_csum     <= '0;
            r_error    <= 1'b0;
          end
        end
        S_RECV: begin
          if (w_take) begin
            r_word     <= w_word_shift;
            r_csum     <= r_csum ^ byte_in;
            r_byte_idx <= r_byte_idx + 2'd1;
            // Write port is loaded on the 4th byte so mem_we lines up with the WRITE cycle.
            if (r_byte_idx == 2'd3) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_addr[ADDR_WIDTH-1:0];
              r_mem_wdata <= w_word_shift;
            end
          end
        end
        S_WRITE: begin
          r_addr <= w_addr_inc;
        end
        S_CHECK: begin
          if (w_take) begin
            r_done  <= 1'b1;
            r_error <= (byte_in != r_csum);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign error     = r_error;

endmodule
